// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking load controller sitting in front of the 128x64
// direct-mapped data cache. Hits return one cycle after the handshake. A miss
// issues a tagged LOAD on the memory bus and waits for the data with the
// matching tag. It then fills the line through write port 1 and returns the
// data to the processor.
//
// Optional feature: define DCACHE_PREFETCH_EN to enable next-line prefetch.
// After each demand fill the controller probes line+1 and, on a miss, fetches
// it through write port 2. Without the macro the prefetch states are not
// built and write port 2 is tied to zero.
module dcache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 7,
    parameter int OFF_W  = 3,
    parameter int TAG_W  = ADDR_W - IDX_W - OFF_W,
    parameter int DATA_W = 64,
    parameter int MTAG_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [MTAG_W-1:0] mem2proc_response,
    input  logic [DATA_W-1:0] mem2proc_data,
    input  logic [MTAG_W-1:0] mem2proc_tag,
    output logic [IDX_W-1:0]  rd1_idx,
    output logic [TAG_W-1:0]  rd1_tag,
    input  logic [DATA_W-1:0] rd1_data,
    input  logic              rd1_valid,
    output logic              wr1_en,
    output logic [IDX_W-1:0]  wr1_idx,
    output logic [TAG_W-1:0]  wr1_tag,
    output logic [DATA_W-1:0] wr1_data,
    output logic              wr2_en,
    output logic [IDX_W-1:0]  wr2_idx,
    output logic [TAG_W-1:0]  wr2_tag,
    output logic [DATA_W-1:0] wr2_data
);

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MREQ    = 3'd1,
        S_MWAIT   = 3'd2
`ifdef DCACHE_PREFETCH_EN
        , S_PF_CHK  = 3'd3,
        S_PF_REQ  = 3'd4,
        S_PF_WAIT = 3'd5
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Line under service: the missing demand line, or the prefetch line once
    // the prefetch probe has missed.
    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    // Memory tag of the outstanding demand load; 0 means nothing outstanding.
    logic [MTAG_W-1:0]   r_mtag;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;

    logic [TAG_W-1:0]    w_req_tag;
    logic [IDX_W-1:0]    w_req_idx;
    logic                w_hs;
    logic                w_match;
    logic                w_granted;
    logic                w_unused_off;

    assign w_req_tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign w_req_idx    = req_addr[OFF_W +: IDX_W];
    assign w_hs         = req_valid && req_ready;
    assign w_granted    = (mem2proc_response != '0);
    // The pending tag is only compared once it has been registered, so a data
    // return in the same cycle as the grant can never match.
    assign w_match      = (r_state == S_MWAIT) && (r_mtag != '0) && (mem2proc_tag == r_mtag);
    // The byte offset does not take part in the lookup.
    assign w_unused_off = ^req_addr[OFF_W-1:0];

    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;

`ifdef DCACHE_PREFETCH_EN
    logic [MTAG_W-1:0]      r_pf_mtag;
    logic [TAG_W+IDX_W-1:0] w_pf_line;
    logic                   w_pf_match;

    // The 29-bit line address wraps to 0 past all-ones.
    assign w_pf_line  = {r_tag, r_idx} + 1'b1;
    assign w_pf_match = (r_state == S_PF_WAIT) && (r_pf_mtag != '0) && (mem2proc_tag == r_pf_mtag);
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_hs && !rd1_valid) w_next_state = S_MREQ;
            S_MREQ:  if (w_granted) w_next_state = S_MWAIT;
`ifdef DCACHE_PREFETCH_EN
            S_MWAIT:   if (w_match) w_next_state = S_PF_CHK;
            S_PF_CHK:  w_next_state = rd1_valid ? S_IDLE : S_PF_REQ;
            S_PF_REQ:  if (w_granted) w_next_state = S_PF_WAIT;
            S_PF_WAIT: if (w_pf_match) w_next_state = S_IDLE;
`else
            S_MWAIT:   if (w_match) w_next_state = S_IDLE;
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state: handshake, memory command,
    // cache read port and fill write ports.
    always_comb begin
        req_ready        = 1'b0;
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        rd1_idx          = '0;
        rd1_tag          = '0;
        wr1_en           = 1'b0;
        wr1_idx          = '0;
        wr1_tag          = '0;
        wr1_data         = '0;
        wr2_en           = 1'b0;
        wr2_idx          = '0;
        wr2_tag          = '0;
        wr2_data         = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                rd1_idx   = w_req_idx;
                rd1_tag   = w_req_tag;
            end
            S_MREQ: begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = {r_tag, r_idx, {OFF_W{1'b0}}};
            end
            S_MWAIT: begin
                if (w_match) begin
                    wr1_en   = 1'b1;
                    wr1_idx  = r_idx;
                    wr1_tag  = r_tag;
                    wr1_data = mem2proc_data;
                end
            end
`ifdef DCACHE_PREFETCH_EN
            S_PF_CHK: begin
                rd1_idx = w_pf_line[IDX_W-1:0];
                rd1_tag = w_pf_line[TAG_W+IDX_W-1:IDX_W];
            end
            S_PF_REQ: begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = {r_tag, r_idx, {OFF_W{1'b0}}};
            end
            S_PF_WAIT: begin
                if (w_pf_match) begin
                    wr2_en   = 1'b1;
                    wr2_idx  = r_idx;
                    wr2_tag  = r_tag;
                    wr2_data = mem2proc_data;
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath: latch the missing line, capture memory grant tags and
    // register the one-cycle load response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag        <= '0;
            r_idx        <= '0;
            r_mtag       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (r_state == S_IDLE && w_hs) begin
                if (rd1_valid) begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= rd1_data;
                end else begin
                    r_tag <= w_req_tag;
                    r_idx <= w_req_idx;
                end
            end
            if (r_state == S_MREQ && w_granted) r_mtag <= mem2proc_response;
            if (w_match) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= mem2proc_data;
                r_mtag       <= '0;
            end
`ifdef DCACHE_PREFETCH_EN
            // Reuse the line registers for the prefetch target once the probe misses.
            if (r_state == S_PF_CHK && !rd1_valid) begin
                r_tag <= w_pf_line[TAG_W+IDX_W-1:IDX_W];
                r_idx <= w_pf_line[IDX_W-1:0];
            end
`endif
        end
    end

`ifdef DCACHE_PREFETCH_EN
    // Pending memory tag of the prefetch load, kept apart from the demand tag.
    always_ff @(posedge clock) begin
        if (reset)                                  r_pf_mtag <= '0;
        else if (r_state == S_PF_REQ && w_granted)  r_pf_mtag <= mem2proc_response;
        else if (w_pf_match)                        r_pf_mtag <= '0;
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl. It uses a behavioural 128-line cache
// array and drives the memory bus by hand. Inputs change on the falling edge,
// and outputs are checked 1 ns later.
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [6:0]  rd1_idx;
    logic [21:0] rd1_tag;
    logic [63:0] rd1_data;
    logic        rd1_valid;
    logic        wr1_en, wr2_en;
    logic [6:0]  wr1_idx, wr2_idx;
    logic [21:0] wr1_tag, wr2_tag;
    logic [63:0] wr1_data, wr2_data;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [63:0] D1 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] D2 = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DX = 64'hBAD0_BAD0_BAD0_BAD0;

    dcache_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .rd1_idx(rd1_idx), .rd1_tag(rd1_tag), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_idx(wr2_idx), .wr2_tag(wr2_tag), .wr2_data(wr2_data)
    );

    always #5 clock = ~clock;

    // Behavioural cache memory: combinational read, write on the rising edge.
    logic        c_vld  [128];
    logic [21:0] c_tag  [128];
    logic [63:0] c_data [128];

    assign rd1_valid = c_vld[rd1_idx] && (c_tag[rd1_idx] == rd1_tag);
    assign rd1_data  = c_data[rd1_idx];

    always @(posedge clock) begin
        if (wr1_en) begin
            c_vld[wr1_idx]  <= 1'b1;
            c_tag[wr1_idx]  <= wr1_tag;
            c_data[wr1_idx] <= wr1_data;
        end
        if (wr2_en) begin
            c_vld[wr2_idx]  <= 1'b1;
            c_tag[wr2_idx]  <= wr2_tag;
            c_data[wr2_idx] <= wr2_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // With prefetch compiled in, a demand fill is followed by a probe of the
    // next line. This task answers that prefetch so later tests start in IDLE.
    task automatic pf_drain();
`ifdef DCACHE_PREFETCH_EN
        if (!rd1_valid) begin
            @(negedge clock); mem2proc_response = 4'd15;
            @(negedge clock); mem2proc_response = 4'd0; mem2proc_tag = 4'd15; mem2proc_data = '0;
            @(negedge clock); mem2proc_tag = 4'd0;
        end
`endif
    endtask

    logic [31:0] hit_addr [3];
    logic [63:0] hit_data [3];

    initial begin
        for (int i = 0; i < 128; i++) begin
            c_vld[i] = 1'b0; c_tag[i] = '0; c_data[i] = '0;
        end
        hit_addr[0] = 32'h0000_0408; hit_data[0] = D1;
        hit_addr[1] = 32'h0000_1010; hit_data[1] = D2;
        hit_addr[2] = 32'h0000_3018; hit_data[2] = D3;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0;
        mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;

        // Reset state
        @(negedge clock); @(negedge clock);
        reset = 1'b0; #1;
        chk("rst_ready",  req_ready, 1);
        chk("rst_resp",   resp_valid, 0);
        chk("rst_cmd",    proc2mem_command, 0);
        chk("rst_wr1",    wr1_en, 0);
        chk("rst_wr2",    wr2_en, 0);
        chk("rst_data",   resp_data, 0);

        // Test 1: cold miss at 0x408, memory tag 3
        @(negedge clock); req_valid = 1'b1; req_addr = 32'h0000_0408; #1;
        chk("t1_rd1_idx", rd1_idx, 7'h01);
        chk("t1_rd1_tag", rd1_tag, 22'h000001);
        @(negedge clock); req_valid = 1'b0; mem2proc_response = 4'd3; #1;
        chk("t1_cmd",     proc2mem_command, 1);
        chk("t1_addr",    proc2mem_addr, 32'h0000_0408);
        chk("t1_ready",   req_ready, 0);
        @(negedge clock); mem2proc_response = 4'd0; mem2proc_tag = 4'd3; mem2proc_data = D1; #1;
        chk("t1_cmd_none", proc2mem_command, 0);
        chk("t1_wr1_en",  wr1_en, 1);
        chk("t1_wr1_idx", wr1_idx, 7'h01);
        chk("t1_wr1_tag", wr1_tag, 22'h000001);
        chk("t1_wr1_dat", wr1_data, D1);
        chk("t1_no_resp", resp_valid, 0);
        @(negedge clock); mem2proc_tag = 4'd0; mem2proc_data = '0; #1;
        chk("t1_resp",    resp_valid, 1);
        chk("t1_rdata",   resp_data, D1);
        chk("t1_wr1_off", wr1_en, 0);
        pf_drain();
        @(negedge clock); #1;
        chk("t1_resp_1cy", resp_valid, 0);
        chk("t1_ready_b",  req_ready, 1);

        // Test 2: hit on same line, different offset
        @(negedge clock); req_valid = 1'b1; req_addr = 32'h0000_040C; #1;
        chk("t2_no_cmd",  proc2mem_command, 0);
        @(negedge clock); req_valid = 1'b0; #1;
        chk("t2_resp",    resp_valid, 1);
        chk("t2_rdata",   resp_data, D1);
        chk("t2_no_cmd2", proc2mem_command, 0);
        @(negedge clock); #1;
        chk("t2_resp_1cy", resp_valid, 0);

        // Test 3: grant delayed 5 cycles, foreign tags ignored
        @(negedge clock); req_valid = 1'b1; req_addr = 32'h0000_1010; #1;
        chk("t3_rd1_idx", rd1_idx, 7'h02);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock); req_valid = 1'b0;
            mem2proc_response = (i == 5) ? 4'd7 : 4'd0; #1;
            chk("t3_cmd_hold", proc2mem_command, 1);
            chk("t3_addr",     proc2mem_addr, 32'h0000_1010);
        end
        @(negedge clock); mem2proc_response = 4'd0; mem2proc_tag = 4'd2; mem2proc_data = DX; #1;
        chk("t3_cmd_none", proc2mem_command, 0);
        chk("t3_tag2_ign", wr1_en, 0);
        @(negedge clock); mem2proc_tag = 4'd5; #1;
        chk("t3_tag5_ign", wr1_en, 0);
        chk("t3_no_resp",  resp_valid, 0);
        @(negedge clock); mem2proc_tag = 4'd7; mem2proc_data = D2; #1;
        chk("t3_wr1_en",  wr1_en, 1);
        chk("t3_wr1_idx", wr1_idx, 7'h02);
        chk("t3_wr1_tag", wr1_tag, 22'h000004);
        chk("t3_wr1_dat", wr1_data, D2);
        @(negedge clock); mem2proc_tag = 4'd0; mem2proc_data = '0; #1;
        chk("t3_resp",    resp_valid, 1);
        chk("t3_rdata",   resp_data, D2);
        pf_drain();
        @(negedge clock); #1;
        chk("t3_resp_1cy", resp_valid, 0);

        // Test 4: reset while waiting on tag 4; late return is dropped
        @(negedge clock); req_valid = 1'b1; req_addr = 32'h0000_2000;
        @(negedge clock); req_valid = 1'b0; mem2proc_response = 4'd4; #1;
        chk("t4_cmd",     proc2mem_command, 1);
        chk("t4_addr",    proc2mem_addr, 32'h0000_2000);
        @(negedge clock); mem2proc_response = 4'd0; reset = 1'b1;
        @(negedge clock); reset = 1'b0; #1;
        chk("t4_ready",   req_ready, 1);
        chk("t4_no_resp", resp_valid, 0);
        chk("t4_cmd_none", proc2mem_command, 0);
        @(negedge clock);
        @(negedge clock); mem2proc_tag = 4'd4; mem2proc_data = DX; #1;
        chk("t4_no_wr1",  wr1_en, 0);
        @(negedge clock); mem2proc_tag = 4'd0; mem2proc_data = '0; #1;
        chk("t4_no_resp2", resp_valid, 0);
        chk("t4_ready2",  req_ready, 1);

        // Test 5: fill a third line, then three back-to-back hits
        @(negedge clock); req_valid = 1'b1; req_addr = 32'h0000_3018;
        @(negedge clock); req_valid = 1'b0; mem2proc_response = 4'd1;
        @(negedge clock); mem2proc_response = 4'd0; mem2proc_tag = 4'd1; mem2proc_data = D3; #1;
        chk("t5_wr1_idx", wr1_idx, 7'h03);
        @(negedge clock); mem2proc_tag = 4'd0; mem2proc_data = '0; #1;
        chk("t5_fill_rd", resp_data, D3);
        pf_drain();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k < 3) begin req_valid = 1'b1; req_addr = hit_addr[k]; end
            else req_valid = 1'b0;
            #1;
            chk("t5_ready", req_ready, 1);
            chk("t5_no_cmd", proc2mem_command, 0);
            if (k > 0) begin
                chk("t5_b2b_vld", resp_valid, 1);
                chk("t5_b2b_dat", resp_data, hit_data[k-1]);
            end
        end
        @(negedge clock); #1;
        chk("t5_resp_end", resp_valid, 0);

`ifdef DCACHE_PREFETCH_EN
        // Test 6: demand miss on the last line, prefetch wraps to line 0
        @(negedge clock); req_valid = 1'b1; req_addr = 32'hFFFF_FFF8; #1;
        chk("t6_rd1_idx", rd1_idx, 7'h7F);
        @(negedge clock); req_valid = 1'b0; mem2proc_response = 4'd6; #1;
        chk("t6_addr",    proc2mem_addr, 32'hFFFF_FFF8);
        @(negedge clock); mem2proc_response = 4'd0; mem2proc_tag = 4'd6; mem2proc_data = D2; #1;
        chk("t6_wr1_en",  wr1_en, 1);
        @(negedge clock); mem2proc_tag = 4'd0; mem2proc_data = '0; #1;
        chk("t6_resp",    resp_valid, 1);
        chk("t6_rdata",   resp_data, D2);
        chk("t6_pf_idx",  rd1_idx, 7'h00);
        chk("t6_pf_tag",  rd1_tag, 22'h0);
        chk("t6_ready",   req_ready, 0);
        @(negedge clock); mem2proc_response = 4'd9; #1;
        chk("t6_pf_cmd",  proc2mem_command, 1);
        chk("t6_pf_addr", proc2mem_addr, 32'h0000_0000);
        chk("t6_no_resp", resp_valid, 0);
        @(negedge clock); mem2proc_response = 4'd0; mem2proc_tag = 4'd9; mem2proc_data = D3; #1;
        chk("t6_wr2_en",  wr2_en, 1);
        chk("t6_wr2_idx", wr2_idx, 7'h00);
        chk("t6_wr2_tag", wr2_tag, 22'h0);
        chk("t6_wr2_dat", wr2_data, D3);
        chk("t6_no_wr1",  wr1_en, 0);
        @(negedge clock); mem2proc_tag = 4'd0; mem2proc_data = '0; #1;
        chk("t6_no_resp2", resp_valid, 0);
        chk("t6_wr2_off", wr2_en, 0);
        chk("t6_ready2",  req_ready, 1);
`else
        chk("wr2_tied",   wr2_en, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
